// File: rtl/mem_lsu_sb_pkg.sv
// Shared types and byte-lane helpers for the MEM-stage load/store unit.
// Lanes are big-endian: byte offset k lives in the k-th byte counted from the MSB.
package mem_lsu_sb_pkg;

  typedef enum logic [1:0] {
    OP_LS_BYTE,
    OP_LS_HALFWORD,
    OP_LS_WORD,
    OP_LS_DWORD
  } ls_op_t;

  function automatic int unsigned ls_bytes(input ls_op_t op);
    case (op)
      OP_LS_BYTE:     return 1;
      OP_LS_HALFWORD: return 2;
      OP_LS_WORD:     return 4;
      default:        return 8;
    endcase
  endfunction

  // Address bits below the access size are ignored rather than trapped.
  function automatic logic [2:0] ls_align(input ls_op_t op, input logic [2:0] offset);
    return offset & ~3'(ls_bytes(op) - 1);
  endfunction

  // Byte-enable mask for an access; BE bit (be_width-1-k) covers byte offset k.
  function automatic logic [7:0] ls_be(input ls_op_t op, input logic [2:0] offset,
                                       input int unsigned be_width);
    int unsigned n;
    int unsigned k;
    n = ls_bytes(op);
    k = 32'(ls_align(op, offset));
    return (8'hFF >> (8 - n)) << (be_width - k - n);
  endfunction

endpackage

// File: rtl/mem_lsu_sb_store_buf.sv
// FIFO store buffer with a CAM lookup that reports the youngest matching entry
// and whether its byte enables cover every byte the load needs.
module mem_lsu_sb_store_buf #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SB_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [BE_WIDTH-1:0]   push_be,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic [BE_WIDTH-1:0]   lookup_be,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [BE_WIDTH-1:0]   head_be,
  output logic                  empty,
  output logic                  full,
  output logic                  hit,
  output logic                  hit_covered,
  output logic [DATA_WIDTH-1:0] hit_data
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } sb_entry_t;

  sb_entry_t       entries_q [SB_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] hit_idx;
  logic [PtrW-1:0] idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SB_DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        entries_q[tail_q] <= '{addr: push_addr, data: push_data, be: push_be};
        tail_q            <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q && entries_q[idx].addr == lookup_addr) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign hit_data    = entries_q[hit_idx].data;
  assign hit_covered = hit && ((entries_q[hit_idx].be & lookup_be) == lookup_be);
  assign head_addr   = entries_q[head_q].addr;
  assign head_data   = entries_q[head_q].data;
  assign head_be     = entries_q[head_q].be;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(SB_DEPTH));

endmodule

// File: rtl/mem_lsu_sb.sv
// MEM-stage load/store unit: lane placement, load extraction and forwarding,
// cache port arbitration between loads and store-buffer drain, and stall logic.
module mem_lsu_sb
  import mem_lsu_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SB_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_inst,
  input  logic                  store_inst,
  input  ls_op_t                ls_op,
  input  logic                  ls_sext,
  input  logic [ADDR_WIDTH-1:0] agu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  sb_drain,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  stall,
  output logic                  sb_empty,
  output logic                  cache_rd,
  output logic                  cache_wr,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wr_data,
  output logic [BE_WIDTH-1:0]   cache_wr_be,
  input  logic [DATA_WIDTH-1:0] cache_data,
  input  logic                  cache_waitrequest
);

  localparam int unsigned OffW = $clog2(BE_WIDTH);

  logic [2:0]            off;
  int unsigned           n_bytes;
  int unsigned           shamt;
  logic [DATA_WIDTH-1:0] size_mask;
  logic [BE_WIDTH-1:0]   acc_be;
  logic [DATA_WIDTH-1:0] st_placed;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  sb_full, sb_hit, sb_covered, sb_push, sb_pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data, hit_data;
  logic [BE_WIDTH-1:0]   head_be;

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                    input int unsigned sh,
                                                    input logic [DATA_WIDTH-1:0] mask,
                                                    input logic sext);
    logic [DATA_WIDTH-1:0] raw;
    logic                  sign;
    raw  = (word >> sh) & mask;
    sign = |(raw & (mask & ~(mask >> 1)));
    return (sext && sign) ? (raw | ~mask) : raw;
  endfunction

  always_comb begin
    off            = '0;
    off[OffW-1:0]  = agu_result[OffW-1:0];
    n_bytes        = ls_bytes(ls_op);
    shamt          = 8 * (BE_WIDTH - 32'(ls_align(ls_op, off)) - n_bytes);
    size_mask      = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 8 * n_bytes);
    acc_be         = BE_WIDTH'(ls_be(ls_op, off, BE_WIDTH));
    st_placed      = (store_data & size_mask) << shamt;
  end

  assign word_addr = {agu_result[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};

  mem_lsu_sb_store_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .SB_DEPTH   (SB_DEPTH)
  ) u_store_buf (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (sb_push),
    .push_addr   (word_addr),
    .push_data   (st_placed),
    .push_be     (acc_be),
    .pop         (sb_pop),
    .lookup_addr (word_addr),
    .lookup_be   (acc_be),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .head_be     (head_be),
    .empty       (sb_empty),
    .full        (sb_full),
    .hit         (sb_hit),
    .hit_covered (sb_covered),
    .hit_data    (hit_data)
  );

  // A load that misses the buffer owns the cache port; the drain retries next cycle.
  always_comb begin
    cache_rd      = load_inst && !sb_hit;
    cache_wr      = !sb_empty && !cache_rd;
    sb_pop        = cache_wr && !cache_waitrequest;
    stall         = (store_inst && sb_full)
                 || (sb_drain && !sb_empty)
                 || (load_inst && (sb_hit ? !sb_covered : cache_waitrequest));
    sb_push       = store_inst && !stall && !sb_full;
    cache_addr    = cache_rd ? word_addr : (cache_wr ? head_addr : '0);
    cache_wr_data = cache_wr ? head_data : '0;
    cache_wr_be   = cache_wr ? head_be : '0;
    if (load_inst) begin
      result = extract(sb_hit ? hit_data : cache_data, shamt, size_mask, ls_sext);
    end else begin
      result = DATA_WIDTH'(agu_result);
    end
  end

endmodule
